round_arbiter: RTL and testbench

Round controller for the reaction game: it arms the seconds timer, waits for the first valid button press from player A or B, and scores the round. If the timer expires first, the round is declared a timeout. It is the initiator and consumer of the timer handshake: it drives the timer's `active` enable and reacts to the timer's `done` flag. It accumulates scores and ends the match at a configured score.

---
 rtl/round_arbiter_pkg.sv | 24 ++
 rtl/round_arbiter_rise_detect.sv | 25 ++
 rtl/round_arbiter.sv | 135 +++++++++++++
 tb/tb_round_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/round_arbiter_pkg.sv
// Shared encodings for the reaction-game round controller:
// FSM state codes and round-winner codes.
package round_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_RUN       = 2'b01,
    ST_RESULT    = 2'b10,
    ST_MATCH_END = 2'b11
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Indices into the packed vector of raw inputs fed to the rise detectors.
  localparam int IDX_START = 0;
  localparam int IDX_BTN_A = 1;
  localparam int IDX_BTN_B = 2;
  localparam int IDX_TIMER = 3;
  localparam int N_INPUTS  = 4;

endpackage

// File: rtl/round_arbiter_rise_detect.sv
// Two-flop synchronizer on a raw level input with a one-cycle rise output.
// A level held high produces exactly one rise.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_rise
);

  logic r_q;
  logic r_qq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q  <= 1'b0;
      r_qq <= 1'b0;
    end else begin
      r_q  <= i_level;
      r_qq <= r_q;
    end
  end

  assign o_rise = r_q & ~r_qq;

endmodule

// File: rtl/round_arbiter.sv
// Round controller: arms the seconds timer, scores the first valid button
// rise (or a timeout), and ends the match when a score reaches MAX_SCORE.
module round_arbiter
  import round_arbiter_pkg::*;
#(
  parameter int MAX_SCORE = 5,
  parameter int SCORE_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               btn_a,
  input  logic               btn_b,
  input  logic               timer_done,
  output logic               timer_active,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic [1:0]         round_winner,
  output logic               round_done,
  output logic               match_over,
  output logic [1:0]         state
);

  localparam logic [SCORE_W-1:0] MAX_SCORE_V = SCORE_W'(MAX_SCORE);

  logic [N_INPUTS-1:0] w_raw;
  logic [N_INPUTS-1:0] w_rise;

  assign w_raw[IDX_START] = start;
  assign w_raw[IDX_BTN_A] = btn_a;
  assign w_raw[IDX_BTN_B] = btn_b;
  assign w_raw[IDX_TIMER] = timer_done;

  generate
    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_rise
      rise_detect u_rise (
        .clk     (clk),
        .reset   (reset),
        .i_level (w_raw[gi]),
        .o_rise  (w_rise[gi])
      );
    end
  endgenerate

  logic w_start_rise;
  logic w_a_rise;
  logic w_b_rise;
  logic w_timer_rise;

  assign w_start_rise = w_rise[IDX_START];
  assign w_a_rise     = w_rise[IDX_BTN_A];
  assign w_b_rise     = w_rise[IDX_BTN_B];
  assign w_timer_rise = w_rise[IDX_TIMER];

  state_t             r_state;
  state_t             w_state_next;
  logic [SCORE_W-1:0] r_score_a;
  logic [SCORE_W-1:0] r_score_b;
  logic [SCORE_W-1:0] w_score_a_next;
  logic [SCORE_W-1:0] w_score_b_next;
  logic [1:0]         r_winner;
  logic [1:0]         w_winner_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_score_a <= '0;
      r_score_b <= '0;
      r_winner  <= WIN_NONE;
    end else begin
      r_state   <= w_state_next;
      r_score_a <= w_score_a_next;
      r_score_b <= w_score_b_next;
      r_winner  <= w_winner_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_score_a_next = r_score_a;
    w_score_b_next = r_score_b;
    w_winner_next  = r_winner;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_rise) begin
          w_state_next  = ST_RUN;
          w_winner_next = WIN_NONE;
        end
      end
      ST_RUN: begin
        // Button rises outrank a simultaneous timer rise.
        if (w_a_rise && w_b_rise) begin
          w_winner_next = WIN_DRAW;
          w_state_next  = ST_RESULT;
        end else if (w_a_rise) begin
          w_winner_next  = WIN_A;
          w_score_a_next = r_score_a + 1'b1;
          w_state_next   = ST_RESULT;
        end else if (w_b_rise) begin
          w_winner_next  = WIN_B;
          w_score_b_next = r_score_b + 1'b1;
          w_state_next   = ST_RESULT;
        end else if (w_timer_rise) begin
          w_winner_next = WIN_DRAW;
          w_state_next  = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (r_score_a == MAX_SCORE_V || r_score_b == MAX_SCORE_V) begin
          w_state_next = ST_MATCH_END;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_MATCH_END: begin
        if (w_start_rise) begin
          w_score_a_next = '0;
          w_score_b_next = '0;
          w_winner_next  = WIN_NONE;
          w_state_next   = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign timer_active = (r_state == ST_RUN);
  assign round_done   = (r_state == ST_RESULT);
  assign match_over   = (r_state == ST_MATCH_END);
  assign score_a      = r_score_a;
  assign score_b      = r_score_b;
  assign round_winner = r_winner;
  assign state        = r_state;

endmodule

// File: tb/tb_round_arbiter.sv
// Directed bench for round_arbiter: hand-computed expectations checked with
// immediate assertions after each step.
module tb_round_arbiter;

  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          btn_a = 1'b0;
  logic          btn_b = 1'b0;
  logic          timer_done = 1'b0;
  logic          timer_active;
  logic [SW-1:0] score_a;
  logic [SW-1:0] score_b;
  logic [1:0]    round_winner;
  logic          round_done;
  logic          match_over;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  round_arbiter #(.MAX_SCORE(5), .SCORE_W(SW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .btn_a        (btn_a),
    .btn_b        (btn_b),
    .timer_done   (timer_done),
    .timer_active (timer_active),
    .score_a      (score_a),
    .score_b      (score_b),
    .round_winner (round_winner),
    .round_done   (round_done),
    .match_over   (match_over),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
    $display("check %-18s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  // Start pulse; after it the controller should be in RUN.
  task automatic start_round(input string tag);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    chk({tag, "_run"}, state, 1);
    chk({tag, "_tact"}, timer_active, 1);
  endtask

  initial begin
    // Reset
    tick(2);
    chk("rst_state", state, 0);
    chk("rst_tact", timer_active, 0);
    chk("rst_sa", score_a, 0);
    chk("rst_sb", score_b, 0);
    chk("rst_win", round_winner, 0);
    chk("rst_done", round_done, 0);
    chk("rst_mo", match_over, 0);
    reset = 1'b0;
    tick(1);

    // A wins: effect two edges after the button goes high
    start_round("r1");
    chk("r1_win0", round_winner, 0);
    btn_a = 1'b1;
    tick(1);
    chk("r1_still_run", state, 1);
    tick(1);
    chk("r1_state", state, 2);
    chk("r1_done", round_done, 1);
    chk("r1_tact", timer_active, 0);
    chk("r1_win", round_winner, 1);
    chk("r1_sa", score_a, 1);
    chk("r1_sb", score_b, 0);
    btn_a = 1'b0;
    tick(1);
    chk("r1_idle", state, 0);
    chk("r1_done_off", round_done, 0);
    chk("r1_win_hold", round_winner, 1);

    // Simultaneous A and B -> draw
    start_round("r2");
    chk("r2_win0", round_winner, 0);
    btn_a = 1'b1;
    btn_b = 1'b1;
    tick(2);
    chk("r2_state", state, 2);
    chk("r2_win", round_winner, 3);
    chk("r2_sa", score_a, 1);
    chk("r2_sb", score_b, 0);
    btn_a = 1'b0;
    btn_b = 1'b0;
    tick(1);
    chk("r2_idle", state, 0);

    // Timeout, then timer held high into the next RUN
    start_round("r3");
    timer_done = 1'b1;
    tick(2);
    chk("r3_state", state, 2);
    chk("r3_win", round_winner, 3);
    chk("r3_sa", score_a, 1);
    chk("r3_sb", score_b, 0);
    tick(1);
    chk("r3_idle", state, 0);
    start_round("r4");
    tick(4);
    chk("r4_held_run", state, 1);
    chk("r4_held_done", round_done, 0);
    timer_done = 1'b0;
    tick(2);
    timer_done = 1'b1;
    tick(2);
    chk("r4_state", state, 2);
    chk("r4_win", round_winner, 3);
    timer_done = 1'b0;
    tick(1);
    chk("r4_idle", state, 0);

    // B rise with timer rise on the same edge -> B wins
    start_round("r5");
    btn_b = 1'b1;
    timer_done = 1'b1;
    tick(2);
    chk("r5_state", state, 2);
    chk("r5_win", round_winner, 2);
    chk("r5_sb", score_b, 1);
    chk("r5_sa", score_a, 1);
    btn_b = 1'b0;
    timer_done = 1'b0;
    tick(1);
    chk("r5_idle", state, 0);

    // B wins until the match ends at 5
    for (int i = 2; i <= 5; i++) begin
      start_round($sformatf("b%0d", i));
      btn_b = 1'b1;
      tick(2);
      chk($sformatf("b%0d_done", i), round_done, 1);
      chk($sformatf("b%0d_win", i), round_winner, 2);
      chk($sformatf("b%0d_sb", i), score_b, i);
      chk($sformatf("b%0d_mo_res", i), match_over, 0);
      btn_b = 1'b0;
      tick(1);
      chk($sformatf("b%0d_next", i), state, (i == 5) ? 3 : 0);
      chk($sformatf("b%0d_mo", i), match_over, (i == 5) ? 1 : 0);
    end

    // Buttons ignored in MATCH_END; start returns to IDLE with cleared scores
    btn_a = 1'b1;
    tick(3);
    chk("me_state", state, 3);
    chk("me_sa", score_a, 1);
    chk("me_tact", timer_active, 0);
    btn_a = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    chk("me_idle", state, 0);
    chk("me_sa0", score_a, 0);
    chk("me_sb0", score_b, 0);
    chk("me_win0", round_winner, 0);
    chk("me_mo0", match_over, 0);
    tick(1);
    chk("me_not_run", state, 0);

    // Buttons in IDLE are discarded
    btn_a = 1'b1;
    btn_b = 1'b1;
    tick(3);
    chk("idle_state", state, 0);
    chk("idle_sa", score_a, 0);
    chk("idle_sb", score_b, 0);
    btn_a = 1'b0;
    btn_b = 1'b0;
    tick(2);

    // Score one, then reset mid-RUN
    start_round("r6");
    btn_a = 1'b1;
    tick(2);
    chk("r6_sa", score_a, 1);
    btn_a = 1'b0;
    tick(1);
    start_round("r7");
    reset = 1'b1;
    tick(1);
    chk("rr_state", state, 0);
    chk("rr_tact", timer_active, 0);
    chk("rr_sa", score_a, 0);
    reset = 1'b0;
    tick(1);

    // Held button counts only once
    start_round("r8");
    btn_a = 1'b1;
    tick(2);
    chk("r8_sa", score_a, 1);
    tick(1);
    start_round("r9");
    tick(4);
    chk("r9_held_run", state, 1);
    chk("r9_held_sa", score_a, 1);
    timer_done = 1'b1;
    tick(2);
    chk("r9_win", round_winner, 3);
    chk("r9_sa", score_a, 1);
    timer_done = 1'b0;
    btn_a = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
